// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared identifiers for the memory port arbiter.
//   - ARB_ID_INST / ARB_ID_DATA : issuer tag values stored in the tag FIFO
//   - arb_state_e               : grant FSM encoding (IDLE / HOLD_I / HOLD_D)
//   - arb_pick()                : combinational winner select for the IDLE state
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam logic ARB_ID_INST = 1'b0;
    localparam logic ARB_ID_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_FSM_IDLE   = 2'b00,
        ARB_FSM_HOLD_I = 2'b01,
        ARB_FSM_HOLD_D = 2'b10
    } arb_state_e;

    // On contention prefer_i decides; otherwise whichever source is valid wins.
    // With nothing valid the fetch side is nominally selected (harmless: valid=0).
    function automatic logic arb_pick(input logic i_v, input logic d_v, input logic prefer_i);
        if (i_v && d_v) return prefer_i ? ARB_ID_INST : ARB_ID_DATA;
        if (d_v)        return ARB_ID_DATA;
        return ARB_ID_INST;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_tag_fifo.sv
// -----------------------------------------------------------------------------
// arb_tag_fifo
//   In-order 1-bit tag FIFO recording which channel issued each accepted
//   memory request. DEPTH must be a power of 2 so the pointers wrap naturally.
// Ports
//   clk, rst        : clock / asynchronous active-high reset
//   push_i, push_id_i : enqueue issuer id (ignored when full)
//   pop_i           : dequeue head (ignored when empty)
//   full_o, empty_o : occupancy flags
//   count_o         : occupancy, 0..DEPTH
//   head_o          : id at the head of the queue
// -----------------------------------------------------------------------------
module arb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     push_id_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i  & ~empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_id_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory request/response port between the fetch channel (i_*)
//   and the data channel (d_*). A grant FSM holds the selected source stable
//   while memory backpressures; every accepted request pushes its issuer id
//   into an in-order tag FIFO, and the FIFO head steers each response back.
//
// Configuration
//   ARB_ROUND_ROBIN_EN : when defined, contention is resolved in favour of the
//                        source not granted last (last_grant resets to data, so
//                        fetch wins the first tie). Undefined: data beats fetch.
//
// Ports
//   clk, rst                  : clock / asynchronous active-high reset
//   i_req_*, i_r*             : fetch request / response channel
//   d_req_*, d_r*             : data request / response channel (loads+stores)
//   m_req_*, m_r*             : shared memory port
//   outstanding               : accepted-but-unanswered requests (0..MAX_OUT)
//   err_spurious              : sticky, a response arrived with nothing pending
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [ADDR_W-1:0]        i_req_addr,
    input  logic                     i_req_valid,
    output logic                     i_req_ready,
    output logic [DATA_W-1:0]        i_rdata,
    output logic                     i_rvalid,
    input  logic                     i_rready,

    input  logic [ADDR_W-1:0]        d_req_addr,
    input  logic                     d_req_wen,
    input  logic [DATA_W/8-1:0]      d_req_wstrb,
    input  logic [DATA_W-1:0]        d_req_wdata,
    input  logic                     d_req_valid,
    output logic                     d_req_ready,
    output logic [DATA_W-1:0]        d_rdata,
    output logic                     d_rvalid,
    input  logic                     d_rready,

    output logic [ADDR_W-1:0]        m_req_addr,
    output logic                     m_req_wen,
    output logic [DATA_W/8-1:0]      m_req_wstrb,
    output logic [DATA_W-1:0]        m_req_wdata,
    output logic                     m_req_valid,
    input  logic                     m_req_ready,
    input  logic [DATA_W-1:0]        m_rdata,
    input  logic                     m_rvalid,
    output logic                     m_rready,

    output logic [$clog2(MAX_OUT):0] outstanding,
    output logic                     err_spurious
);

    arb_state_e state_q, state_d;

    logic fifo_full;
    logic fifo_empty;
    logic fifo_head;
    logic sel;
    logic sel_valid;
    logic prefer_i;
    logic req_fire;
    logic rsp_fire;
    logic err_q, err_d;

    // ---------------------------------------------------------------- priority
`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (req_fire) last_grant_d = sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant_q <= ARB_ID_DATA;
        else     last_grant_q <= last_grant_d;
    end

    assign prefer_i = (last_grant_q == ARB_ID_DATA);
`else
    assign prefer_i = 1'b0;
`endif

    // ------------------------------------------------------- grant FSM: state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ARB_FSM_IDLE;
        else     state_q <= state_d;
    end

    // -------------------------------------------------- grant FSM: next state
    // A held source that withdraws its valid would otherwise wedge the port,
    // so a dropped valid also releases the hold.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_FSM_IDLE: begin
                if (m_req_valid && !m_req_ready)
                    state_d = (sel == ARB_ID_DATA) ? ARB_FSM_HOLD_D : ARB_FSM_HOLD_I;
            end
            ARB_FSM_HOLD_I,
            ARB_FSM_HOLD_D: begin
                if (req_fire || !sel_valid) state_d = ARB_FSM_IDLE;
            end
            default: state_d = ARB_FSM_IDLE;
        endcase
    end

    // ------------------------------------------------------ grant FSM: output
    always_comb begin
        case (state_q)
            ARB_FSM_HOLD_I: sel = ARB_ID_INST;
            ARB_FSM_HOLD_D: sel = ARB_ID_DATA;
            default:        sel = arb_pick(i_req_valid, d_req_valid, prefer_i);
        endcase
    end

    // ------------------------------------------------------------ request mux
    // No bypass: a full FIFO blocks issue even if a pop lands this cycle.
    assign sel_valid   = (sel == ARB_ID_DATA) ? d_req_valid : i_req_valid;
    assign m_req_valid = sel_valid & ~fifo_full;
    assign req_fire    = m_req_valid & m_req_ready;

    assign i_req_ready = (sel == ARB_ID_INST) & m_req_ready & ~fifo_full;
    assign d_req_ready = (sel == ARB_ID_DATA) & m_req_ready & ~fifo_full;

    assign m_req_addr  = (sel == ARB_ID_DATA) ? d_req_addr  : i_req_addr;
    assign m_req_wen   = (sel == ARB_ID_DATA) & d_req_wen;
    assign m_req_wstrb = (sel == ARB_ID_DATA) ? d_req_wstrb : '0;
    assign m_req_wdata = (sel == ARB_ID_DATA) ? d_req_wdata : '0;

    // --------------------------------------------------------------- tag FIFO
    arb_tag_fifo #(
        .DEPTH     (MAX_OUT)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (req_fire),
        .push_id_i (sel),
        .pop_i     (rsp_fire),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (outstanding),
        .head_o    (fifo_head)
    );

    // -------------------------------------------------------- response steer
    // With nothing pending the response is stale (e.g. reset mid-flight):
    // accept it so memory drains, but show it to neither channel.
    always_comb begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        m_rready = 1'b1;
        if (!fifo_empty) begin
            if (fifo_head == ARB_ID_INST) begin
                i_rvalid = m_rvalid;
                m_rready = i_rready;
            end else begin
                d_rvalid = m_rvalid;
                m_rready = d_rready;
            end
        end
    end

    assign rsp_fire = m_rvalid & m_rready & ~fifo_empty;
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

    // ----------------------------------------------------------- sticky error
    assign err_d = err_q | (m_rvalid & fifo_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err_spurious = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int MAX_OUT = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_req_valid;
    logic              i_req_ready;
    logic [DATA_W-1:0] i_rdata;
    logic              i_rvalid;
    logic              i_rready;
    logic [ADDR_W-1:0] d_req_addr;
    logic              d_req_wen;
    logic [DATA_W/8-1:0] d_req_wstrb;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_req_valid;
    logic              d_req_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;
    logic              d_rready;
    logic [ADDR_W-1:0] m_req_addr;
    logic              m_req_wen;
    logic [DATA_W/8-1:0] m_req_wstrb;
    logic [DATA_W-1:0] m_req_wdata;
    logic              m_req_valid;
    logic              m_req_ready;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rvalid;
    logic              m_rready;
    logic [$clog2(MAX_OUT):0] outstanding;
    logic              err_spurious;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .MAX_OUT(MAX_OUT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_addr(i_req_addr), .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_req_addr(d_req_addr), .d_req_wen(d_req_wen), .d_req_wstrb(d_req_wstrb),
        .d_req_wdata(d_req_wdata), .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .m_req_addr(m_req_addr), .m_req_wen(m_req_wen), .m_req_wstrb(m_req_wstrb),
        .m_req_wdata(m_req_wdata), .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .outstanding(outstanding), .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        i_req_addr = '0; i_req_valid = 1'b0; i_rready = 1'b1;
        d_req_addr = '0; d_req_wen = 1'b0; d_req_wstrb = '0; d_req_wdata = '0;
        d_req_valid = 1'b0; d_rready = 1'b1;
        m_req_ready = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
    endtask

    // Single uncontended request accepted in one cycle.
    task automatic issue(input logic is_d, input logic [ADDR_W-1:0] addr);
        m_req_ready = 1'b1;
        if (is_d) begin d_req_valid = 1'b1; d_req_addr = addr; end
        else      begin i_req_valid = 1'b1; i_req_addr = addr; end
        #1;
        chk(is_d ? "issue_d_ready" : "issue_i_ready", is_d ? d_req_ready : i_req_ready, 1'b1);
        chk("issue_addr", m_req_addr, addr);
        step();
        i_req_valid = 1'b0; d_req_valid = 1'b0; m_req_ready = 1'b0;
    endtask

    // One memory response, both channels ready; expect it on the to_d side.
    task automatic resp(input logic [DATA_W-1:0] data, input logic to_d);
        m_rvalid = 1'b1; m_rdata = data; i_rready = 1'b1; d_rready = 1'b1;
        #1;
        chk("rsp_i_rvalid", i_rvalid, !to_d);
        chk("rsp_d_rvalid", d_rvalid, to_d);
        chk("rsp_rdata", to_d ? d_rdata : i_rdata, data);
        chk("rsp_m_rready", m_rready, 1'b1);
        step();
        m_rvalid = 1'b0;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outstanding", outstanding, 0);
        chk("rst_m_req_valid", m_req_valid, 1'b0);
        chk("rst_err", err_spurious, 1'b0);
        chk("rst_i_rvalid", i_rvalid, 1'b0);
        chk("rst_d_rvalid", d_rvalid, 1'b0);
        rst = 1'b0;
        step();

`ifdef ARB_ROUND_ROBIN_EN
        // Round robin: continuous contention alternates I,D,I,D from reset.
        i_req_valid = 1'b1; i_req_addr = 32'h300;
        d_req_valid = 1'b1; d_req_addr = 32'h400;
        m_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_i_ready", i_req_ready, (k % 2) == 0);
            chk("rr_d_ready", d_req_ready, (k % 2) == 1);
            chk("rr_addr", m_req_addr, ((k % 2) == 0) ? 32'h300 : 32'h400);
            step();
        end
        chk("rr_outstanding", outstanding, 4);
        clr();
        for (int k = 0; k < 4; k++) resp(32'h10 + k, (k % 2) == 1);
        chk("rr_drained", outstanding, 0);
`else
        // Fixed priority: data beats fetch, then fetch goes next.
        i_req_valid = 1'b1; i_req_addr = 32'h100;
        d_req_valid = 1'b1; d_req_addr = 32'h200; d_req_wen = 1'b1;
        d_req_wstrb = 4'hC; d_req_wdata = 32'hDEADBEEF;
        m_req_ready = 1'b1;
        #1;
        chk("t1_d_ready", d_req_ready, 1'b1);
        chk("t1_i_ready", i_req_ready, 1'b0);
        chk("t1_addr", m_req_addr, 32'h200);
        chk("t1_wen", m_req_wen, 1'b1);
        chk("t1_wstrb", m_req_wstrb, 4'hC);
        chk("t1_wdata", m_req_wdata, 32'hDEADBEEF);
        step();
        d_req_valid = 1'b0; d_req_wen = 1'b0;
        #1;
        chk("t1_i_next", i_req_ready, 1'b1);
        chk("t1_addr_i", m_req_addr, 32'h100);
        chk("t1_wen_i", m_req_wen, 1'b0);
        step();
        clr();
        chk("t1_outstanding", outstanding, 2);
        resp(32'h55, 1'b1);
        resp(32'h66, 1'b0);
        chk("t1_drained", outstanding, 0);
`endif

        // Hold under backpressure: fetch stays granted while data arrives.
        i_req_valid = 1'b1; i_req_addr = 32'h1000;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin d_req_valid = 1'b1; d_req_addr = 32'h2000; end
            #1;
            chk("t2_hold_addr", m_req_addr, 32'h1000);
            chk("t2_hold_valid", m_req_valid, 1'b1);
            chk("t2_d_blocked", d_req_ready, 1'b0);
            step();
        end
        m_req_ready = 1'b1;
        #1;
        chk("t2_i_accept", i_req_ready, 1'b1);
        chk("t2_d_not", d_req_ready, 1'b0);
        chk("t2_acc_addr", m_req_addr, 32'h1000);
        step();
        i_req_valid = 1'b0;
        #1;
        chk("t2_d_next", d_req_ready, 1'b1);
        chk("t2_d_addr", m_req_addr, 32'h2000);
        step();
        clr();
        resp(32'h11, 1'b0);
        resp(32'h22, 1'b1);
        chk("t2_drained", outstanding, 0);

        // Fill to MAX_OUT, no bypass on the popping cycle, in-order routing.
        issue(1'b0, 32'h10);
        issue(1'b1, 32'h14);
        issue(1'b0, 32'h18);
        issue(1'b1, 32'h1C);
        i_req_valid = 1'b1; i_req_addr = 32'h50; m_req_ready = 1'b1;
        #1;
        chk("t3_full_ready", i_req_ready, 1'b0);
        chk("t3_full_mvalid", m_req_valid, 1'b0);
        chk("t3_full_count", outstanding, 4);
        m_rvalid = 1'b1; m_rdata = 32'hA;
        #1;
        chk("t3_rA_i", i_rvalid, 1'b1);
        chk("t3_rA_data", i_rdata, 32'hA);
        chk("t3_rA_d", d_rvalid, 1'b0);
        chk("t3_nobypass", m_req_valid, 1'b0);
        step();
        m_rvalid = 1'b0; i_req_valid = 1'b0; m_req_ready = 1'b0;
        chk("t3_count3", outstanding, 3);
        resp(32'hB, 1'b1);
        resp(32'hC, 1'b0);
        resp(32'hD, 1'b1);
        chk("t3_drained", outstanding, 0);

        // Fetch response backpressure holds the response.
        issue(1'b0, 32'h80);
        m_rvalid = 1'b1; m_rdata = 32'h44; i_rready = 1'b0; d_rready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t4_m_rready", m_rready, 1'b0);
            chk("t4_i_rvalid", i_rvalid, 1'b1);
            chk("t4_d_rvalid", d_rvalid, 1'b0);
            step();
            chk("t4_count", outstanding, 1);
        end
        i_rready = 1'b1;
        #1;
        chk("t4_release", m_rready, 1'b1);
        chk("t4_d_rvalid_rel", d_rvalid, 1'b0);
        step();
        m_rvalid = 1'b0;
        chk("t4_drained", outstanding, 0);

        // Reset mid-flight, then stale responses are dropped and flagged.
        issue(1'b0, 32'h90);
        issue(1'b1, 32'h94);
        chk("t5_pre_count", outstanding, 2);
        rst = 1'b1;
        #1;
        chk("t5_rst_count", outstanding, 0);
        step();
        rst = 1'b0;
        step();
        chk("t5_err_clear", err_spurious, 1'b0);
        m_rvalid = 1'b1; m_rdata = 32'h77;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t5_drop_rready", m_rready, 1'b1);
            chk("t5_drop_i", i_rvalid, 1'b0);
            chk("t5_drop_d", d_rvalid, 1'b0);
            step();
            chk("t5_err_set", err_spurious, 1'b1);
        end
        m_rvalid = 1'b0;
        step();
        chk("t5_err_sticky", err_spurious, 1'b1);
        chk("t5_count", outstanding, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
